// File: rtl/reg_file_pkg.sv
// Shared definitions for the 32x32 general-purpose register file.
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;
  localparam int ZERO_REG       = 0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: address decode, zero-register override, optional write bypass.
// Build option: REG_FILE_BYPASS_EN adds the forwarding mux and its write-side inputs.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_reg,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  output logic [DATA_W-1:0] rd_data
`ifdef REG_FILE_BYPASS_EN
  ,
  input  logic              reset_b,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data
`endif
);

  // NOTE: rd_data gets a default before any condition so no latch is inferred.
  always_comb begin
    rd_data = regs[rd_reg];
`ifdef REG_FILE_BYPASS_EN
    if (reset_b && (reg_write == 1'b1) && (wr_reg == rd_reg)) begin
      rd_data = wr_data;
    end
`endif
    // Applied last so neither storage nor bypass can leak through register 0.
    if (rd_reg == ADDR_W'(ZERO_REG)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Register file: 2**ADDR_W x DATA_W, two combinational reads, one clocked write, r0 fixed at 0.
// Build option: REG_FILE_BYPASS_EN makes a same-cycle write visible on the read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              clk,
  input  logic              reset_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem  [1:DEPTH-1];
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  // An X on reg_write compares unknown, which the if below treats as no write.
  assign wr_en = (reg_write == 1'b1) && (wr_reg != ADDR_W'(ZERO_REG));

  // NOTE: the array is built from flops rather than RAM because every entry must
  // clear asynchronously the moment reset_b falls; a RAM macro cannot do that.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_reg] <= wr_data;
    end
  end

  always_comb begin
    regs[0] = '0;
    for (int i = 1; i < DEPTH; i++) regs[i] = mem[i];
  end

  reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
    .rd_reg    (rd_reg1),
    .regs      (regs),
    .rd_data   (rd_data1)
`ifdef REG_FILE_BYPASS_EN
    ,
    .reset_b   (reset_b),
    .reg_write (reg_write),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data)
`endif
  );

  reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
    .rd_reg    (rd_reg2),
    .regs      (regs),
    .rd_data   (rd_data2)
`ifdef REG_FILE_BYPASS_EN
    ,
    .reset_b   (reset_b),
    .reg_write (reg_write),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data)
`endif
  );

  a_reg_write_known: assert property (@(posedge clk) disable iff (!reset_b) !$isunknown(reg_write));

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;
  import reg_file_pkg::*;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_addr_t rd_reg1, rd_reg2, wr_reg;
  reg_data_t wr_data, rd_data1, rd_data2;
  logic      reg_write, clk, reset_b;

  int checks = 0;
  int errors = 0;

  reg_file dut (
    .rd_reg1   (rd_reg1),
    .rd_reg2   (rd_reg2),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .reg_write (reg_write),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .clk       (clk),
    .reset_b   (reset_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #90000;
    $display("FAIL watchdog: simulation time limit reached, got still running, required finished");
    $fatal(1, "watchdog expired");
  end

  // Reads every address on both ports and expects zero.
  task automatic sweep_all_zero(input string tag);
    for (int a = 0; a < NUM_REGS; a++) begin
      rd_reg1 = reg_addr_t'(a);
      rd_reg2 = reg_addr_t'(NUM_REGS - 1 - a);
      #1;
      checks++;
      if (rd_data1 !== '0) begin
        errors++;
        $display("FAIL %s port1 addr %0d: got %h required 0", tag, a, rd_data1);
      end
      checks++;
      if (rd_data2 !== '0) begin
        errors++;
        $display("FAIL %s port2 addr %0d: got %h required 0", tag, NUM_REGS - 1 - a, rd_data2);
      end
    end
  endtask

  task automatic test_reset;
    reset_b = 1'b0; reg_write = 1'b0; wr_reg = '0; wr_data = '0; rd_reg1 = '0; rd_reg2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sweep_all_zero("reset_initial");
    reset_b = 1'b1;
    // Store a value, then clear it with a short pulse that spans no clock edge.
    wr_reg = 5'd3; wr_data = 32'hAAAA_5555; reg_write = 1'b1;
    @(posedge clk); #1;
    reg_write = 1'b0; rd_reg1 = 5'd3;
    #1;
    checks++;
    if (rd_data1 !== 32'hAAAA_5555) begin
      errors++; $display("FAIL reset_prewrite: got %h required aaaa5555", rd_data1);
    end
    reset_b = 1'b0;
    #1;
    checks++;
    if (rd_data1 !== '0) begin
      errors++; $display("FAIL reset_async_clear: got %h required 0", rd_data1);
    end
    #2;
    reset_b = 1'b1;
    @(negedge clk);
    sweep_all_zero("reset_pulse");
  endtask

  task automatic test_write_disable;
    @(negedge clk);
    reg_write = 1'b0; wr_reg = 5'd5; wr_data = 32'h0000_1234; rd_reg1 = 5'd5; rd_reg2 = 5'd5;
    #1;
    checks++;
    if (rd_data2 !== '0) begin
      errors++; $display("FAIL wr_disable_pre: got %h required 0", rd_data2);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_data1 !== '0) begin
      errors++; $display("FAIL wr_disable_post: got %h required 0", rd_data1);
    end
  endtask

  task automatic test_sweep;
    reg_data_t exp_pre;
    for (int k = 2; k < NUM_REGS; k++) begin
      @(negedge clk);
      reg_write = 1'b1; wr_data = 32'd10; wr_reg = reg_addr_t'(k);
      rd_reg1 = reg_addr_t'(k - 1); rd_reg2 = reg_addr_t'(k);
      #1;
      exp_pre = BYPASS ? 32'd10 : 32'd0;
      checks++;
      if (rd_data1 !== ((k == 2) ? 32'd0 : 32'd10)) begin
        errors++; $display("FAIL sweep_trail reg %0d: got %h required %h", k - 1, rd_data1, (k == 2) ? 32'd0 : 32'd10);
      end
      checks++;
      if (rd_data2 !== exp_pre) begin
        errors++; $display("FAIL sweep_pre reg %0d: got %h required %h", k, rd_data2, exp_pre);
      end
      @(posedge clk); #1;
      checks++;
      if (rd_data2 !== 32'd10) begin
        errors++; $display("FAIL sweep_post reg %0d: got %h required a", k, rd_data2);
      end
    end
    @(negedge clk);
    reg_write = 1'b0; rd_reg1 = 5'd1; rd_reg2 = 5'd31;
    #1;
    checks++;
    if (rd_data1 !== '0) begin
      errors++; $display("FAIL sweep_unwritten reg 1: got %h required 0", rd_data1);
    end
    checks++;
    if (rd_data2 !== 32'd10) begin
      errors++; $display("FAIL sweep_last reg 31: got %h required a", rd_data2);
    end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    reg_write = 1'b1; wr_reg = 5'd0; wr_data = 32'hDEAD_BEEF; rd_reg1 = 5'd0; rd_reg2 = 5'd0;
    #1;
    checks++;
    if (rd_data2 !== '0) begin
      errors++; $display("FAIL zero_reg_pre: got %h required 0", rd_data2);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_data1 !== '0) begin
      errors++; $display("FAIL zero_reg_post port1: got %h required 0", rd_data1);
    end
    checks++;
    if (rd_data2 !== '0) begin
      errors++; $display("FAIL zero_reg_post port2: got %h required 0", rd_data2);
    end
    reg_write = 1'b0;
  endtask

  task automatic test_same_address;
    reg_data_t exp_pre;
    @(negedge clk);
    reg_write = 1'b1; wr_reg = 5'd7; wr_data = 32'h11;
    @(negedge clk);
    wr_data = 32'h22; rd_reg1 = 5'd7; rd_reg2 = 5'd7;
    #1;
    exp_pre = BYPASS ? 32'h22 : 32'h11;
    checks++;
    if (rd_data1 !== exp_pre) begin
      errors++; $display("FAIL same_addr_pre port1: got %h required %h", rd_data1, exp_pre);
    end
    checks++;
    if (rd_data2 !== exp_pre) begin
      errors++; $display("FAIL same_addr_pre port2: got %h required %h", rd_data2, exp_pre);
    end
    @(posedge clk); #1;
    reg_write = 1'b0;
    checks++;
    if (rd_data1 !== 32'h22) begin
      errors++; $display("FAIL same_addr_post port1: got %h required 22", rd_data1);
    end
    checks++;
    if (rd_data2 !== 32'h22) begin
      errors++; $display("FAIL same_addr_post port2: got %h required 22", rd_data2);
    end
  endtask

  task automatic test_back_to_back;
    reg_data_t vals [4] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reg_write = 1'b1; wr_reg = reg_addr_t'(12 + i); wr_data = vals[i];
    end
    @(negedge clk);
    reg_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_reg1 = reg_addr_t'(12 + i); rd_reg2 = reg_addr_t'(15 - i);
      #1;
      checks++;
      if (rd_data1 !== vals[i]) begin
        errors++; $display("FAIL b2b port1 reg %0d: got %h required %h", 12 + i, rd_data1, vals[i]);
      end
      checks++;
      if (rd_data2 !== vals[3 - i]) begin
        errors++; $display("FAIL b2b port2 reg %0d: got %h required %h", 15 - i, rd_data2, vals[3 - i]);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    reset_b = 1'b0; reg_write = 1'b1; wr_reg = 5'd9; wr_data = 32'h55; rd_reg1 = 5'd9; rd_reg2 = 5'd12;
    #1;
    checks++;
    if (rd_data1 !== '0) begin
      errors++; $display("FAIL reset_mid_pre: got %h required 0", rd_data1);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_data1 !== '0) begin
      errors++; $display("FAIL reset_mid_edge: got %h required 0", rd_data1);
    end
    @(negedge clk);
    reg_write = 1'b0; reset_b = 1'b1;
    sweep_all_zero("reset_mid_after");
  endtask

  initial begin
    test_reset;
    test_write_disable;
    test_sweep;
    test_zero_reg;
    test_same_address;
    test_back_to_back;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
